// File: rtl/iob_wb2iob_master.sv
// Wishbone classic slave to IOb native master bridge for the MAC DMA port.
// Each single-word Wishbone cycle is registered and replayed as one IOb
// transaction. The result returns as a one-cycle ack, or as a one-cycle err
// if memory stays silent for 2^TIMEOUT_W-1 cycles.
module iob_wb2iob_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic                  wb_we_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  valid,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Counter value in the last REQ cycle before the timeout fires.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  abort_q, abort_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    abort_d = abort_q;

    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d  = wb_adr_i;
          wdata_d = wb_dat_i;
          wstrb_d = wb_we_i ? wb_sel_i : '0;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (wb_we_i && (wb_sel_i == '0)) begin
            // Write with no lanes selected: nothing to send to memory.
            state_d = RESP;
            ack_d   = 1'b1;
          end else begin
            valid_d = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (ready) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          if (wstrb_q == '0) rdat_d = rdata;
          // A master that left the cycle gets no response.
          if (abort_q || !wb_cyc_i) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
          end
        end else begin
          if (!wb_cyc_i) abort_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            valid_d = 1'b0;
            abort_d = 1'b0;
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end

      RESP: begin
        // Strobe is deliberately ignored here; the finished cycle may still hold it.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign valid    = valid_q;
  assign address  = addr_q;
  assign wdata    = wdata_q;
  assign wstrb    = wstrb_q;
  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_iob_wb2iob_master.sv
// Self-checking bench for iob_wb2iob_master: table vectors, random transfers
// against a transaction-level model, and hand-written abort/reset sequences.
module tb_iob_wb2iob_master;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned TW     = 4;
  localparam int          TO_CYC = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wb_adr_i;
  logic [SW-1:0] wb_sel_i;
  logic          wb_we_i;
  logic [DW-1:0] wb_dat_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          valid;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] rdata;
  logic          ready;

  iob_wb2iob_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_dat_i(wb_dat_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  // One transfer: stimulus, memory latency (valid cycle carrying ready, 0 = never)
  // and the expected observation.
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    int            lat;
    logic [DW-1:0] rdata;
    int            exp_nvalid;
    int            exp_lat;
    logic          exp_ack;
    logic          exp_err;
    logic [DW-1:0] exp_dat;
    logic [SW-1:0] exp_wstrb;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] last_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome of one transfer from the bus rules.
  function automatic vec_t model(input vec_t v, input logic [DW-1:0] last);
    vec_t e;
    e = v;
    e.exp_wstrb = v.we ? v.sel : '0;
    if (v.we && (v.sel == '0)) begin
      e.exp_nvalid = 0;      e.exp_lat = 1;
      e.exp_ack = 1'b1;      e.exp_err = 1'b0;  e.exp_dat = last;
    end else if (v.lat == 0 || v.lat > TO_CYC) begin
      e.exp_nvalid = TO_CYC; e.exp_lat = TO_CYC + 1;
      e.exp_ack = 1'b0;      e.exp_err = 1'b1;  e.exp_dat = last;
    end else begin
      e.exp_nvalid = v.lat;  e.exp_lat = v.lat + 1;
      e.exp_ack = 1'b1;      e.exp_err = 1'b0;
      e.exp_dat = v.we ? last : v.rdata;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic [SW-1:0] sel, input int lat, input logic [DW-1:0] rd,
                              input int env, input int elat, input logic eack, input logic eerr,
                              input logic [DW-1:0] edat, input logic [SW-1:0] estrb);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.lat = lat; v.rdata = rd;
    v.exp_nvalid = env; v.exp_lat = elat; v.exp_ack = eack; v.exp_err = eerr;
    v.exp_dat = edat; v.exp_wstrb = estrb;
    return v;
  endfunction

  // Runs one Wishbone transfer starting at a negedge and returns at the negedge
  // of the cycle after the response, so a following call is back-to-back.
  task automatic xfer(input vec_t v, input string tag);
    int nvalid = 0, resp_c = 0, ack_cnt = 0, err_cnt = 0, bad = 0;
    logic [DW-1:0] dat_at = '0;
    logic fell = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel; ready = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (valid) begin
        if (fell) bad++;
        nvalid++;
        if (address !== v.adr || wdata !== v.dat || wstrb !== v.exp_wstrb) bad++;
      end else if (nvalid > 0) begin
        fell = 1'b1;
      end
      if (wb_ack_o) ack_cnt++;
      if (wb_err_o) err_cnt++;
      if ((wb_ack_o || wb_err_o) && resp_c == 0) begin
        resp_c = c;
        dat_at = wb_dat_o;
      end
      if (resp_c != 0 && c == resp_c + 1) break;
      if (valid && v.lat > 0 && nvalid == v.lat) begin
        ready = 1'b1; rdata = v.rdata;
      end else begin
        ready = 1'b0; rdata = $urandom;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; ready = 1'b0;
    check({tag, ".nvalid"}, 32'(nvalid), 32'(v.exp_nvalid));
    check({tag, ".latency"}, 32'(resp_c), 32'(v.exp_lat));
    check({tag, ".ack"}, 32'(ack_cnt), 32'(v.exp_ack));
    check({tag, ".err"}, 32'(err_cnt), 32'(v.exp_err));
    check({tag, ".dat_o"}, dat_at, v.exp_dat);
    check({tag, ".iob_stable"}, 32'(bad), 32'd0);
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1'b0, 32'h0000_1000, 32'h0,         4'hF, 3,  32'hDEAD_BEEF, 3,  4,  1'b1, 1'b0, 32'hDEAD_BEEF, 4'h0);
    tbl[1] = mk(1'b1, 32'h0000_2004, 32'h1234_5678, 4'h6, 1,  32'h1111_1111, 1,  2,  1'b1, 1'b0, 32'hDEAD_BEEF, 4'h6);
    tbl[2] = mk(1'b1, 32'h0000_2008, 32'hFFFF_FFFF, 4'h0, 1,  32'h2222_2222, 0,  1,  1'b1, 1'b0, 32'hDEAD_BEEF, 4'h0);
    tbl[3] = mk(1'b0, 32'h0000_3000, 32'h0,         4'hF, 0,  32'h3333_3333, 15, 16, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'h0);
    tbl[4] = mk(1'b0, 32'h0000_3004, 32'h0,         4'hF, 1,  32'hCAFE_F00D, 1,  2,  1'b1, 1'b0, 32'hCAFE_F00D, 4'h0);
    tbl[5] = mk(1'b0, 32'h0000_3008, 32'h0,         4'hF, 15, 32'h0BAD_F00D, 15, 16, 1'b1, 1'b0, 32'h0BAD_F00D, 4'h0);
    tbl[6] = mk(1'b0, 32'h0000_0007, 32'h0,         4'h1, 2,  32'h7654_3210, 2,  3,  1'b1, 1'b0, 32'h7654_3210, 4'h0);

    rst = 1'b0; wb_adr_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_dat_i = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rdata = '0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.address", address, 32'd0);
    check("reset.wdata", wdata, 32'd0);
    check("reset.wstrb", 32'(wstrb), 32'd0);
    check("reset.dat_o", wb_dat_o, 32'd0);
    check("reset.ack", 32'(wb_ack_o), 32'd0);
    check("reset.err", 32'(wb_err_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, run back-to-back.
    for (int i = 0; i < 7; i++) xfer(tbl[i], $sformatf("vec%0d", i));
    last_dat = tbl[6].exp_dat;

    // Abort: master drops the cycle two cycles into REQ, memory answers late.
    begin
      int nv = 0, resp = 0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_4000; wb_sel_i = 4'hF;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (valid) nv++;
        if (wb_ack_o || wb_err_o) resp++;
        if (valid && nv == 2) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
        if (valid && nv == 5) begin ready = 1'b1; rdata = 32'h4444_4444; end
        else ready = 1'b0;
      end
      check("abort.nvalid", 32'(nv), 32'd5);
      check("abort.no_response", 32'(resp), 32'd0);
      v = mk(1'b0, 32'h0000_4004, 32'h0, 4'hF, 2, 32'h5555_AAAA, 0, 0, 1'b0, 1'b0, '0, '0);
      v = model(v, last_dat);
      xfer(v, "after_abort");
      last_dat = v.exp_dat;
    end

    // Reset while a request is outstanding.
    begin
      int waited = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0000_5008;
      wb_dat_i = 32'hA5A5_5A5A; wb_sel_i = 4'hF; ready = 1'b0;
      do begin
        @(negedge clk);
        waited++;
      end while (!valid && waited < 10);
      check("rstmid.valid_before", 32'(valid), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rstmid.valid", 32'(valid), 32'd0);
      check("rstmid.ack", 32'(wb_ack_o), 32'd0);
      check("rstmid.err", 32'(wb_err_o), 32'd0);
      check("rstmid.address", address, 32'd0);
      check("rstmid.wstrb", 32'(wstrb), 32'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      last_dat = '0;
      v = mk(1'b1, 32'h0000_600C, 32'h0F0F_0F0F, 4'h9, 1, 32'h0, 0, 0, 1'b0, 1'b0, '0, '0);
      v = model(v, last_dat);
      xfer(v, "after_reset");
      last_dat = v.exp_dat;
    end

    // Random transfers against the transaction model.
    for (int i = 0; i < 25; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.sel   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      v.adr   = 32'($urandom) & 32'hFFFF_FFFC;
      v.dat   = $urandom;
      v.lat   = int'($urandom_range(0, 6));
      v.rdata = $urandom;
      v = model(v, last_dat);
      xfer(v, $sformatf("rnd%0d", i));
      last_dat = v.exp_dat;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
